irq_ctrl: RTL and testbench

Parametrised interrupt controller sitting between the system-level peripherals (serial port, keyboard, Ethernet, future devices) and the CPU interrupt input. It replaces the per-device wiring of request and acknowledge lines with one block. The block latches requests per source in level or edge mode, masks them, and presents a single prioritised interrupt to the CPU. Software claims and completes interrupts through a small register window decoded by the memory controller.

---
 rtl/irq_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised interrupt controller.
// Latches per-source requests (level or rising-edge), masks them, tracks
// in-service sources, and drives a single fixed-priority interrupt to the CPU.
// Software uses a four-register window: PENDING, MASK, CLAIM, COMPLETE.
// Optional build macro: IRQ_SYNC_EN adds a two-flop synchroniser on src_req
// for sources that are asynchronous to clk (one extra cycle of latency).

module irq_ctrl #(
    parameter int                NR_SRC    = 4,
    parameter logic [NR_SRC-1:0] EDGE_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR_SRC-1:0] src_req,
    output logic [NR_SRC-1:0] src_ack,
    input  logic [1:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    input  logic              reg_we,
    input  logic              reg_re,
    output logic [31:0]       reg_rdata,
    output logic              cpu_int
);

    // Register window map.
    typedef enum logic [1:0] {
        ADDR_PENDING  = 2'd0,
        ADDR_MASK     = 2'd1,
        ADDR_CLAIM    = 2'd2,
        ADDR_COMPLETE = 2'd3
    } reg_addr_e;

    localparam logic [31:0] NO_CLAIM = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic [NR_SRC-1:0] s_req;
    logic [NR_SRC-1:0] s_prev;

`ifdef IRQ_SYNC_EN
    logic [NR_SRC-1:0] sync_q;

    // Two-flop synchroniser: sync_q is the metastability stage, s_req the second flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of statement order.
        if (rst) begin
            sync_q <= '0;
            s_req  <= '0;
        end else begin
            sync_q <= src_req;
            s_req  <= sync_q;
        end
    end
`else
    // Single registration stage; all sources are assumed synchronous to clk.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs, independent of statement order.
        if (rst) begin
            s_req <= '0;
        end else begin
            s_req <= src_req;
        end
    end
`endif

    // Delayed copy of s_req used for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev <= '0;
        end else begin
            s_prev <= s_req;
        end
    end

    // ------------------------------------------------------------------
    // Core state
    // ------------------------------------------------------------------
    logic [NR_SRC-1:0] pend;
    logic [NR_SRC-1:0] mask;
    logic [NR_SRC-1:0] insvc;

    logic [NR_SRC-1:0] pend_nxt;
    logic [NR_SRC-1:0] mask_nxt;
    logic [NR_SRC-1:0] insvc_nxt;
    logic [31:0]       rdata_nxt;

    logic [NR_SRC-1:0] elig;
    logic [NR_SRC-1:0] edge_set;
    logic [NR_SRC-1:0] claim_oh;
    logic [4:0]        claim_idx;
    logic              claim_any;

    // ------------------------------------------------------------------
    // Register access decode; a read in the same cycle suppresses the write.
    // ------------------------------------------------------------------
    reg_addr_e addr;
    logic      wr_en;
    logic      wr_pending;
    logic      wr_mask;
    logic      wr_complete;
    logic      rd_claim;
    logic      claim_valid;

    assign addr        = reg_addr_e'(reg_addr);
    assign wr_en       = reg_we & ~reg_re;
    assign wr_pending  = wr_en && (addr == ADDR_PENDING);
    assign wr_mask     = wr_en && (addr == ADDR_MASK);
    assign wr_complete = wr_en && (addr == ADDR_COMPLETE);
    assign rd_claim    = reg_re && (addr == ADDR_CLAIM);
    assign claim_valid = rd_claim && claim_any;

    // Upper write-data bits have no function in this block.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, reg_wdata};

    assign elig     = pend & mask & ~insvc;
    assign edge_set = EDGE_MASK & s_req & ~s_prev;

    // Fixed-priority encoder: lowest eligible index wins.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        claim_idx = '0;
        claim_oh  = '0;
        claim_any = |elig;
        for (int i = NR_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                claim_idx   = 5'(i);
                claim_oh    = '0;
                claim_oh[i] = 1'b1;
            end
        end
    end

    // Pending next state: clears first, then edge sets on top so a new edge wins;
    // level sources simply follow the synchronised request.
    always_comb begin
        pend_nxt = pend;
        if (wr_pending) begin
            pend_nxt = pend_nxt & ~(reg_wdata[NR_SRC-1:0] & EDGE_MASK);
        end
        if (claim_valid) begin
            pend_nxt = pend_nxt & ~(claim_oh & EDGE_MASK);
        end
        pend_nxt = ((pend_nxt | edge_set) & EDGE_MASK) | (s_req & ~EDGE_MASK);
    end

    // Mask next state: plain software write.
    always_comb begin
        mask_nxt = mask;
        if (wr_mask) begin
            mask_nxt = reg_wdata[NR_SRC-1:0];
        end
    end

    // In-service next state: set on claim, cleared by COMPLETE of a valid index.
    always_comb begin
        insvc_nxt = insvc;
        if (claim_valid) begin
            insvc_nxt = insvc_nxt | claim_oh;
        end
        if (wr_complete) begin
            for (int i = 0; i < NR_SRC; i++) begin
                if (reg_wdata[4:0] == 5'(i)) begin
                    insvc_nxt[i] = 1'b0;
                end
            end
        end
    end

    // Read data mux; the output register only loads on a read strobe.
    always_comb begin
        rdata_nxt = reg_rdata;
        if (reg_re) begin
            rdata_nxt = '0;
            case (addr)
                ADDR_PENDING:  rdata_nxt[NR_SRC-1:0] = pend;
                ADDR_MASK:     rdata_nxt[NR_SRC-1:0] = mask;
                ADDR_CLAIM:    rdata_nxt = claim_any ? {27'd0, claim_idx} : NO_CLAIM;
                ADDR_COMPLETE: rdata_nxt = '0;
                default:       rdata_nxt = '0;
            endcase
        end
    end

    // State, acknowledge pulse, read data and CPU interrupt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            mask      <= '0;
            insvc     <= '0;
            src_ack   <= '0;
            reg_rdata <= '0;
            cpu_int   <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            mask      <= mask_nxt;
            insvc     <= insvc_nxt;
            src_ack   <= claim_valid ? claim_oh : '0;
            reg_rdata <= rdata_nxt;
            cpu_int   <= |elig;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl (NR_SRC=4, source 0 edge, sources 1..3 level).
// Stimulus pushes expected observations tagged with the cycle they are due;
// a negedge monitor pops and compares them against the DUT outputs.

module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_MASK  = 2'd1;
    localparam logic [1:0] A_CLAIM = 2'd2;
    localparam logic [1:0] A_CMPL  = 2'd3;

    logic        clk;
    logic        rst;
    logic [3:0]  src_req;
    logic [3:0]  src_ack;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [31:0] reg_rdata;
    logic        cpu_int;

    irq_ctrl #(.NR_SRC(4), .EDGE_MASK(4'b0001)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_req   (src_req),
        .src_ack   (src_ack),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .cpu_int   (cpu_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {S_RDATA, S_INT, S_ACK} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input string name, input sig_e sig, input logic [31:0] val, input int dly);
        exp_t e;
        e.name = name;
        e.sig  = sig;
        e.val  = val;
        e.cyc  = cyc + dly;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                case (sb[i].sig)
                    S_RDATA: act = reg_rdata;
                    S_INT:   act = {31'd0, cpu_int};
                    default: act = {28'd0, src_ack};
                endcase
                check(sb[i].name, act, sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string name);
        reg_addr = a;
        reg_re   = 1'b1;
        expect_at(name, S_RDATA, e, 1);
        tick();
        reg_re = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        tick();
        reg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src_req = '0; reg_addr = '0; reg_wdata = '0; reg_we = 1'b0; reg_re = 1'b0;
        tick(); tick();
        expect_at("rst_int",   S_INT,   0, 0);
        expect_at("rst_ack",   S_ACK,   0, 0);
        expect_at("rst_rdata", S_RDATA, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        rd(A_PEND, 0, "rst_pend");
        rd(A_MASK, 0, "rst_mask");

        // Level source 2: latency, claim, ack pulse, block, re-raise after COMPLETE.
        wr(A_MASK, 32'hF);
        tick();
        src_req = 4'b0100;
        expect_at("a_int_lo", S_INT, 0, LAT - 1);
        expect_at("a_int_hi", S_INT, 1, LAT);
        repeat (LAT) tick();
        expect_at("a_ack",     S_ACK, 4, 1);
        expect_at("a_ack_end", S_ACK, 0, 2);
        expect_at("a_int_drop", S_INT, 0, 2);
        rd(A_CLAIM, 2, "a_claim");
        repeat (3) tick();
        expect_at("a_int_blk", S_INT, 0, 0);
        expect_at("a_int_c1",  S_INT, 0, 1);
        expect_at("a_int_c2",  S_INT, 1, 2);
        wr(A_CMPL, 2);
        repeat (2) tick();
        rd(A_CLAIM, 2, "a_claim2");
        src_req = 4'b0000;
        repeat (3) tick();
        wr(A_CMPL, 2);
        repeat (2) tick();
        expect_at("a_idle", S_INT, 0, 0);

        // Priority: sources 3 and 1 together.
        src_req = 4'b1010;
        repeat (LAT + 1) tick();
        expect_at("b_ack1", S_ACK, 4'b0010, 1);
        rd(A_CLAIM, 1, "b_claim1");
        expect_at("b_ack3", S_ACK, 4'b1000, 1);
        rd(A_CLAIM, 3, "b_claim3");
        expect_at("b_ack_none", S_ACK, 0, 1);
        rd(A_CLAIM, 32'hFFFF_FFFF, "b_claim_none");
        expect_at("b_int_off", S_INT, 0, 0);
        rd(A_PEND, 32'hA, "b_pend");
        expect_at("b_cmpl_oob", S_INT, 0, 2);
        wr(A_CMPL, 32'h5);
        tick();
        expect_at("b_cmpl_3", S_INT, 1, 2);
        wr(A_CMPL, 32'h23);
        tick();
        expect_at("b_ack3b", S_ACK, 4'b1000, 1);
        rd(A_CLAIM, 3, "b_claim3b");
        src_req = 4'b0000;
        repeat (3) tick();
        wr(A_CMPL, 1);
        wr(A_CMPL, 3);
        tick();

        // Edge source 0: set, W1C, set/clear collision, claim clears pend.
        src_req = 4'b0001;
        expect_at("c_int_hi", S_INT, 1, LAT);
        tick();
        src_req = 4'b0000;
        repeat (LAT - 2) tick();
        rd(A_PEND, 1, "c_pend_set");
        expect_at("c_int_clr", S_INT, 0, 2);
        wr(A_PEND, 32'hFFFF_FFFF);
        rd(A_PEND, 0, "c_pend_clr");
        src_req = 4'b0001;
        tick();
        src_req = 4'b0000;
        repeat (LAT - 3) tick();
        wr(A_PEND, 1);
        rd(A_PEND, 1, "c_pend_race");
        expect_at("c_ack0", S_ACK, 1, 1);
        rd(A_CLAIM, 0, "c_claim");
        rd(A_PEND, 0, "c_pend_claimed");
        wr(A_CMPL, 0);
        tick();

        // Masking.
        wr(A_MASK, 0);
        src_req = 4'hF;
        repeat (LAT + 2) tick();
        expect_at("d_int_masked", S_INT, 0, 0);
        expect_at("d_ack_none",   S_ACK, 0, 1);
        rd(A_CLAIM, 32'hFFFF_FFFF, "d_claim_none");
        rd(A_PEND, 32'hF, "d_pend");
        expect_at("d_int_mask8", S_INT, 1, 2);
        wr(A_MASK, 32'h8);
        tick();
        expect_at("d_ack3", S_ACK, 4'b1000, 1);
        rd(A_CLAIM, 3, "d_claim");
        expect_at("d_rdata_hold", S_RDATA, 32'h8, 2);
        rd(A_MASK, 32'h8, "d_mask");
        wr(A_MASK, 32'hFFFF_FFFF);
        rd(A_MASK, 32'hF, "d_mask_upper");
        rd(A_CMPL, 0, "d_cmpl_read");
        src_req = 4'b0000;
        wr(A_PEND, 1);
        repeat (3) tick();
        wr(A_CMPL, 3);
        tick();

        // Reset in the cycle after a CLAIM read.
        src_req = 4'b0100;
        repeat (LAT + 1) tick();
        expect_at("e_ack",      S_ACK,   4, 1);
        expect_at("e_int",      S_INT,   1, 1);
        expect_at("e_ack_rst",  S_ACK,   0, 2);
        expect_at("e_int_rst",  S_INT,   0, 2);
        expect_at("e_rdat_rst", S_RDATA, 0, 2);
        rd(A_CLAIM, 2, "e_claim");
        rst = 1'b1;
        src_req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        rd(A_PEND, 0, "e_pend");
        rd(A_MASK, 0, "e_mask");
        expect_at("e_int_after", S_INT, 0, 0);

        repeat (4) tick();
        foreach (sb[i]) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: expectation never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
